// File: rtl/tft_bounce_pic.sv
// Pixel source for the TFT path: a solid box bouncing over a flat background, 1-cycle latency.
// Optional TFT_BOUNCE_COLOR_CYCLE_EN steps the box colour through an 8-entry table on each bounce.
module tft_bounce_pic #(
  parameter int unsigned H_VALID   = 480,
  parameter int unsigned V_VALID   = 272,
  parameter int unsigned BOX_W     = 32,
  parameter int unsigned BOX_H     = 32,
  parameter int unsigned STEP      = 2,
  parameter int unsigned FRAME_DIV = 1,
  parameter logic [15:0] BG_COLOR  = 16'hFFFF,
  parameter logic [15:0] BOX_COLOR = 16'hF800
) (
  input  logic        clk_9m,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [15:0] pix_data
);

  localparam int unsigned CNT_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
  localparam logic [10:0] X_MAX  = 11'(H_VALID - BOX_W);
  localparam logic [10:0] Y_MAX  = 11'(V_VALID - BOX_H);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [9:0]  STEP10 = 10'(STEP);

  // Direction states: {dir_x, dir_y}, right/down = 1
  localparam logic [1:0] ST_LU = 2'b00;
  localparam logic [1:0] ST_LD = 2'b01;
  localparam logic [1:0] ST_RU = 2'b10;
  localparam logic [1:0] ST_RD = 2'b11;

  logic [9:0]       r_box_x, r_box_y;
  logic [1:0]       r_dir;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [15:0]      r_pix_data;

  logic [9:0]  w_box_x_nxt, w_box_y_nxt;
  logic        w_flip_x, w_flip_y;
  logic        w_right, w_down;
  logic [1:0]  w_dir_nxt;
  logic        w_fe, w_move, w_in_box, w_off;
  logic [10:0] w_px, w_py, w_bx, w_by;
  logic [15:0] w_box_color;

  assign w_px = {1'b0, pix_x};
  assign w_py = {1'b0, pix_y};
  assign w_bx = {1'b0, r_box_x};
  assign w_by = {1'b0, r_box_y};

  assign w_off    = (pix_x == 10'h3FF) || (pix_y == 10'h3FF);
  assign w_in_box = (w_px >= w_bx) && (w_px < w_bx + 11'(BOX_W)) &&
                    (w_py >= w_by) && (w_py < w_by + 11'(BOX_H));

  assign w_fe   = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));
  assign w_move = w_fe && (r_frame_cnt == CNT_LAST);

  assign w_right = (r_dir == ST_RD) || (r_dir == ST_RU);
  assign w_down  = (r_dir == ST_RD) || (r_dir == ST_LD);

  // Clamp at the edges so a STEP that does not divide the travel range never overshoots
  always_comb begin
    w_box_x_nxt = r_box_x;
    w_flip_x    = 1'b0;
    if (w_right) begin
      if (w_bx + STEP11 >= X_MAX) begin
        w_box_x_nxt = X_MAX[9:0];
        w_flip_x    = 1'b1;
      end else begin
        w_box_x_nxt = r_box_x + STEP10;
      end
    end else begin
      if (w_bx <= STEP11) begin
        w_box_x_nxt = 10'd0;
        w_flip_x    = 1'b1;
      end else begin
        w_box_x_nxt = r_box_x - STEP10;
      end
    end
  end

  always_comb begin
    w_box_y_nxt = r_box_y;
    w_flip_y    = 1'b0;
    if (w_down) begin
      if (w_by + STEP11 >= Y_MAX) begin
        w_box_y_nxt = Y_MAX[9:0];
        w_flip_y    = 1'b1;
      end else begin
        w_box_y_nxt = r_box_y + STEP10;
      end
    end else begin
      if (w_by <= STEP11) begin
        w_box_y_nxt = 10'd0;
        w_flip_y    = 1'b1;
      end else begin
        w_box_y_nxt = r_box_y - STEP10;
      end
    end
  end

  always_comb begin
    w_dir_nxt = ST_LU;
    unique case ({w_right ^ w_flip_x, w_down ^ w_flip_y})
      2'b11:   w_dir_nxt = ST_RD;
      2'b10:   w_dir_nxt = ST_RU;
      2'b01:   w_dir_nxt = ST_LD;
      default: w_dir_nxt = ST_LU;
    endcase
  end

`ifdef TFT_BOUNCE_COLOR_CYCLE_EN
  logic [2:0] r_color_idx;

  always_ff @(posedge clk_9m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_color_idx <= 3'd0;
    end else if (w_move && (w_flip_x || w_flip_y)) begin
      r_color_idx <= r_color_idx + 3'd1;
    end
  end

  always_comb begin
    w_box_color = 16'hF800;
    case (r_color_idx)
      3'd0:    w_box_color = 16'hF800;
      3'd1:    w_box_color = 16'h07E0;
      3'd2:    w_box_color = 16'h001F;
      3'd3:    w_box_color = 16'hFFE0;
      3'd4:    w_box_color = 16'hF81F;
      3'd5:    w_box_color = 16'h07FF;
      3'd6:    w_box_color = 16'hFC00;
      default: w_box_color = 16'h0000;
    endcase
  end
`else
  assign w_box_color = BOX_COLOR;
`endif

  // Position updates at frame end; that cycle's pixel already used the old position
  always_ff @(posedge clk_9m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_box_x     <= 10'd0;
      r_box_y     <= 10'd0;
      r_dir       <= ST_RD;
      r_frame_cnt <= '0;
    end else if (w_fe) begin
      if (w_move) begin
        r_frame_cnt <= '0;
        r_box_x     <= w_box_x_nxt;
        r_box_y     <= w_box_y_nxt;
        r_dir       <= w_dir_nxt;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_9m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pix_data <= 16'h0000;
    end else if (w_off) begin
      r_pix_data <= 16'h0000;
    end else if (w_in_box) begin
      r_pix_data <= w_box_color;
    end else begin
      r_pix_data <= BG_COLOR;
    end
  end

  assign pix_data = r_pix_data;

endmodule

// File: tb/tb_tft_bounce_pic.sv
// Directed bench for tft_bounce_pic: four parameterisations, frame ends driven as single fe cycles.
// Expected colours follow TFT_BOUNCE_COLOR_CYCLE_EN when it is defined.
module tb_tft_bounce_pic;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  px [4];
  logic [9:0]  py [4];
  logic [15:0] pd [4];

  int errors = 0;
  int checks = 0;
  int fe_x [4];
  int fe_y [4];
  logic [15:0] cyc_tab [8];

  localparam logic [15:0] BG = 16'hFFFF;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] exp;
  } vec_t;

  vec_t v_render [5];
  vec_t v_update [4];

  always #5 clk = ~clk;

  tft_bounce_pic u_dut (
    .clk_9m(clk), .sys_rst_n(rst_n), .pix_x(px[0]), .pix_y(py[0]), .pix_data(pd[0])
  );

  tft_bounce_pic #(.STEP(7)) u_s7 (
    .clk_9m(clk), .sys_rst_n(rst_n), .pix_x(px[1]), .pix_y(py[1]), .pix_data(pd[1])
  );

  tft_bounce_pic #(.H_VALID(64), .V_VALID(64)) u_sm (
    .clk_9m(clk), .sys_rst_n(rst_n), .pix_x(px[2]), .pix_y(py[2]), .pix_data(pd[2])
  );

  tft_bounce_pic #(.FRAME_DIV(3)) u_d3 (
    .clk_9m(clk), .sys_rst_n(rst_n), .pix_x(px[3]), .pix_y(py[3]), .pix_data(pd[3])
  );

  function automatic logic [15:0] box_col(int idx);
`ifdef TFT_BOUNCE_COLOR_CYCLE_EN
    return cyc_tab[idx % 8];
`else
    return 16'hF800;
`endif
  endfunction

  task automatic cmp(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < 4; k++) begin
      px[k] = 10'h3FF;
      py[k] = 10'h3FF;
    end
  endtask

  task automatic probe(int k, int x, int y, logic [15:0] exp, string name);
    @(negedge clk);
    px[k] = 10'(x);
    py[k] = 10'(y);
    @(negedge clk);
    cmp($sformatf("%s u%0d (%0d,%0d)", name, k, x, y), pd[k], exp);
    px[k] = 10'h3FF;
    py[k] = 10'h3FF;
  endtask

  // One frame = one cycle at the last active pixel (fe) then one blanking cycle
  task automatic frames(int k, int n);
    repeat (n) begin
      @(negedge clk);
      px[k] = 10'(fe_x[k]);
      py[k] = 10'(fe_y[k]);
      @(negedge clk);
      px[k] = 10'h3FF;
      py[k] = 10'h3FF;
    end
  endtask

  task automatic check_box(int k, int x, int y, logic [15:0] col, string tag);
    probe(k, x, y, col, {tag, " tl"});
    probe(k, x + 31, y, col, {tag, " tr"});
    probe(k, x, y + 31, col, {tag, " bl"});
    probe(k, x + 32, y, BG, {tag, " right"});
    probe(k, x, y + 32, BG, {tag, " below"});
    if (x > 0) probe(k, x - 1, y, BG, {tag, " left"});
    if (y > 0) probe(k, x, y - 1, BG, {tag, " above"});
  endtask

  initial begin
    fe_x = '{479, 479, 63, 479};
    fe_y = '{271, 271, 63, 271};
    cyc_tab = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFE0,
                16'hF81F, 16'h07FF, 16'hFC00, 16'h0000};
    v_render[0] = '{10'd0,    10'd0,  16'hF800};
    v_render[1] = '{10'd31,   10'd31, 16'hF800};
    v_render[2] = '{10'd32,   10'd0,  16'hFFFF};
    v_render[3] = '{10'd0,    10'd32, 16'hFFFF};
    v_render[4] = '{10'h3FF,  10'd5,  16'h0000};
    v_update[0] = '{10'd1,  10'd1,  16'hFFFF};
    v_update[1] = '{10'd2,  10'd2,  16'hF800};
    v_update[2] = '{10'd33, 10'd33, 16'hF800};
    v_update[3] = '{10'd34, 10'd34, 16'hFFFF};

    // Valid in-box coordinates while reset is held: output must stay 0
    for (int k = 0; k < 4; k++) begin
      px[k] = 10'd0;
      py[k] = 10'd0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) cmp($sformatf("reset u%0d", k), pd[k], 16'h0000);
    idle_all();
    rst_n = 1'b1;

    // Back-to-back render vectors, each result one clock after its coordinate
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i > 0) cmp($sformatf("render%0d", i - 1), pd[0], v_render[i-1].exp);
      if (i < 5) begin
        px[0] = v_render[i].x;
        py[0] = v_render[i].y;
      end else begin
        px[0] = 10'h3FF;
        py[0] = 10'h3FF;
      end
    end

    frames(0, 1);
    for (int i = 0; i < 4; i++) begin
      probe(0, int'(v_update[i].x), int'(v_update[i].y), v_update[i].exp, $sformatf("upd%0d", i));
    end

    frames(0, 119);
    check_box(0, 240, 240, box_col(1), "f120");
    frames(0, 1);
    check_box(0, 242, 238, box_col(1), "f121");
    frames(0, 103);
    check_box(0, 448, 32, box_col(2), "f224");
    frames(0, 1);
    check_box(0, 446, 30, box_col(2), "f225");

    frames(1, 63);
    check_box(1, 441, 44, box_col(1), "s7 f63");
    frames(1, 1);
    check_box(1, 448, 37, box_col(2), "s7 f64");
    frames(1, 1);
    check_box(1, 441, 30, box_col(2), "s7 f65");

    frames(2, 15);
    check_box(2, 30, 30, box_col(0), "sm f15");
    frames(2, 1);
    check_box(2, 32, 32, box_col(1), "sm corner");
    frames(2, 1);
    check_box(2, 30, 30, box_col(1), "sm f17");

    frames(3, 2);
    check_box(3, 0, 0, box_col(0), "d3 fe2");
    frames(3, 1);
    check_box(3, 2, 2, box_col(0), "d3 fe3");
    frames(3, 5);
    check_box(3, 4, 4, box_col(0), "d3 fe8");
    frames(3, 1);
    check_box(3, 6, 6, box_col(0), "d3 fe9");

    // Fresh start, then an asynchronous reset between clock edges
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    frames(0, 50);
    @(negedge clk);
    px[0] = 10'd100;
    py[0] = 10'd100;
    @(negedge clk);
    cmp("pre-reset box pixel", pd[0], 16'hF800);
    #2 rst_n = 1'b0;
    #1 cmp("async clear", pd[0], 16'h0000);
    @(negedge clk);
    px[0] = 10'h3FF;
    py[0] = 10'h3FF;
    rst_n = 1'b1;
    check_box(0, 0, 0, 16'hF800, "post-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
